// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for IMem; holds the CPU in reset until a clean load.
// Optional trailing XOR check byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WR_LAST,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_hi_q, cnt_hi_d;
    logic [15:0] count_q, count_d;
    logic [23:0] shift_q, shift_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] words_q, words_d;
    logic        accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_hi_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            bcnt_q   <= '0;
            csum_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            csum_q   <= csum_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            words_q  <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        count_d    = count_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        csum_d     = csum_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        // The word count trails the write strobe by one cycle so mem_addr shows the pre-increment index.
        words_d    = words_q + {15'd0, we_q};
        byte_ready = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: state_d = HDR_HI;
            HDR_HI: begin
                byte_ready = 1'b1;
                accept     = byte_valid;
                if (accept) begin
                    cnt_hi_d = byte_data;
                    csum_d   = csum_q ^ byte_data;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                accept     = byte_valid;
                if (accept) begin
                    count_d = {cnt_hi_q, byte_data};
                    csum_d  = csum_q ^ byte_data;
                    if ({cnt_hi_q, byte_data} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if (32'({cnt_hi_q, byte_data}) > 32'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                accept     = byte_valid;
                if (accept) begin
                    csum_d  = csum_q ^ byte_data;
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], byte_data};
                    if (bcnt_q == 2'd3) begin
                        wdata_d = {shift_q, byte_data};
                        we_d    = 1'b1;
                        // A 4th byte is never within 3 cycles of the previous write, so words_q is settled here.
                        if (words_q + 16'd1 == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = WR_LAST;
`endif
                        end
                    end
                end
            end
            WR_LAST: state_d = DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                accept     = byte_valid;
                if (accept) begin
                    state_d = (byte_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (load_req) begin
                    state_d = HDR_HI;
                    words_d = '0;
                    bcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we       = we_q;
    assign mem_addr     = BASE + ADDR_WIDTH'(words_q);
    assign mem_wdata    = wdata_q;
    assign cpu_reset    = (state_q != DONE);
    assign load_done    = (state_q == DONE);
    assign load_error   = (state_q == ERR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized image loads against a byte-stream reference model.
module tb_imem_loader;

    localparam int AW   = 16;
    localparam int MAXW = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [15:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .load_req(load_req),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    bit done_seen = 0;
    int we_rst_bad = 0;
    logic [47:0] wr_q[$];

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            last_we_cyc = cyc;
            if (!cpu_reset) we_rst_bad++;
        end
        if (load_done && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer bytes in order; returns how many were actually accepted within a cycle budget.
    task automatic drive_bytes(input logic [7:0] q[$], input bit gaps, output int sent);
        int  guard = 0;
        bit  acc;
        sent = 0;
        while (sent < q.size() && guard < q.size() * 4 + 50) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = q[sent];
            end
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            guard++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Reference: count header, N big-endian words at consecutive addresses, optional XOR check byte.
    task automatic run_image(input logic [15:0] n, input logic [31:0] words[$],
                             input bit gaps, input bit bad_cs, input string tag);
        logic [7:0] bq[$];
        logic [7:0] cs;
        bit         exp_err;
        int         exp_wr;
        int         sent;
        cs = n[15:8] ^ n[7:0];
        bq = {n[15:8], n[7:0]};
        exp_err = (int'(n) > MAXW);
        exp_wr  = exp_err ? 0 : words.size();
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                bq.push_back(words[i][b*8 +: 8]);
                cs ^= words[i][b*8 +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            bq.push_back(bad_cs ? (cs ^ 8'h05) : cs);
            if (bad_cs) exp_err = 1;
        end
`endif
        if (load_done || load_error) pulse_load_req();
        wr_q.delete();
        done_seen  = 0;
        we_rst_bad = 0;
        drive_bytes(bq, gaps, sent);
        chk({tag, ".accepted"}, sent, bq.size());
        for (int k = 0; k < 40 && !(load_done || load_error); k++) @(negedge clk);
        @(negedge clk);
        chk({tag, ".status"}, {load_done, load_error, cpu_reset}, exp_err ? 3'b011 : 3'b100);
        chk({tag, ".nwrites"}, wr_q.size(), exp_wr);
        for (int i = 0; i < exp_wr && i < wr_q.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), wr_q[i], {AW'(i), words[i]});
        chk({tag, ".words_loaded"}, words_loaded, exp_wr);
        chk({tag, ".we_rst"}, we_rst_bad, 0);
        if (!exp_err && n != 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (!gaps) chk({tag, ".release"}, done_cyc - last_we_cyc, 1);
`else
            chk({tag, ".release"}, done_cyc - last_we_cyc, 1);
`endif
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ready"}, byte_ready, 1'b0);
        chk({tag, ".we"}, mem_we, 1'b0);
        chk({tag, ".addr"}, mem_addr, 0);
        chk({tag, ".wdata"}, mem_wdata, 0);
        chk({tag, ".flags"}, {cpu_reset, load_done, load_error}, 3'b100);
        chk({tag, ".words"}, words_loaded, 0);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [7:0]  part[$];
        int          sent;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        w = {32'h20010005, 32'h8C220004};
        run_image(16'd2, w, 1'b0, 1'b0, "spec2");
        run_image(16'd2, w, 1'b1, 1'b0, "spec2gap");
        w.delete();
        run_image(16'h0401, w, 1'b0, 1'b0, "overflow");
        run_image(16'd0, w, 1'b0, 1'b0, "empty");
        w = {32'hFFFFFFFF};
        run_image(16'd1, w, 1'b0, 1'b0, "ones");

        for (int t = 0; t < 4; t++) begin
            w.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_image(16'(n), w, 1'(t & 1), 1'b0, $sformatf("rnd%0d", t));
        end

        w.delete();
        for (int i = 0; i < MAXW; i++) w.push_back($urandom);
        run_image(16'(MAXW), w, 1'b0, 1'b0, "maxw");

        if (load_done || load_error) pulse_load_req();
        part = {8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11};
        drive_bytes(part, 1'b0, sent);
        chk("midrst.sent", sent, 7);
        @(negedge clk);
        chk("midrst.pre_words", words_loaded, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        w = {$urandom, $urandom};
        run_image(16'd2, w, 1'b1, 1'b0, "postrst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        w = {32'h01020304};
        run_image(16'd1, w, 1'b0, 1'b0, "cs_good");
        run_image(16'd1, w, 1'b0, 1'b1, "cs_bad");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
